// File: rtl/alarm_match_ctrl_pkg.sv
// Shared types and limits for the alarm-match controller slice.
package alarm_match_ctrl_pkg;

    // Alarm sequencing states
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StArmed    = 2'd1,
        StRinging  = 2'd2,
        StSnoozing = 2'd3
    } alarm_state_e;

    // 24 h BCD limits for the editable alarm fields
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned HR_MAX  = 23;

    // Digit widths: minutes units/tens, hours units/tens
    localparam int unsigned MU_W = 4;
    localparam int unsigned MT_W = 3;
    localparam int unsigned HU_W = 4;
    localparam int unsigned HT_W = 2;

endpackage

// File: rtl/alarm_time_reg.sv
// User-editable alarm time (HH:MM, BCD) with independent minute/hour wrap.
module alarm_time_reg
    import alarm_match_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            set_mode,
    input  logic            c_up_min,
    input  logic            c_down_min,
    input  logic            c_up_hour,
    input  logic            c_down_hour,
    output logic [MU_W-1:0] al_min_units,
    output logic [MT_W-1:0] al_min_tens,
    output logic [HU_W-1:0] al_hr_units,
    output logic [HT_W-1:0] al_hr_tens
);

    localparam logic [MU_W-1:0] MU_LAST = MU_W'(MIN_MAX % 10);
    localparam logic [MT_W-1:0] MT_LAST = MT_W'(MIN_MAX / 10);
    localparam logic [HU_W-1:0] HU_NINE = HU_W'(9);
    localparam logic [HU_W-1:0] HU_LAST = HU_W'(HR_MAX % 10);
    localparam logic [HT_W-1:0] HT_LAST = HT_W'(HR_MAX / 10);

    logic [MU_W-1:0] min_units_q, min_units_d;
    logic [MT_W-1:0] min_tens_q, min_tens_d;
    logic [HU_W-1:0] hr_units_q, hr_units_d;
    logic [HT_W-1:0] hr_tens_q, hr_tens_d;

    // Opposing pulses on the same field cancel out
    logic min_up, min_dn, hr_up, hr_dn;
    assign min_up = set_mode & c_up_min & ~c_down_min;
    assign min_dn = set_mode & c_down_min & ~c_up_min;
    assign hr_up  = set_mode & c_up_hour & ~c_down_hour;
    assign hr_dn  = set_mode & c_down_hour & ~c_up_hour;

    // Minutes: wrap 59 <-> 00, never carries into hours
    always_comb begin
        min_units_d = min_units_q;
        min_tens_d  = min_tens_q;
        if (min_up) begin
            if (min_units_q == MU_LAST) begin
                min_units_d = '0;
                min_tens_d  = (min_tens_q == MT_LAST) ? '0 : min_tens_q + MT_W'(1);
            end else begin
                min_units_d = min_units_q + MU_W'(1);
            end
        end else if (min_dn) begin
            if (min_units_q == '0) begin
                min_units_d = MU_LAST;
                min_tens_d  = (min_tens_q == '0) ? MT_LAST : min_tens_q - MT_W'(1);
            end else begin
                min_units_d = min_units_q - MU_W'(1);
            end
        end
    end

    // Hours: 0-23 in BCD, units roll at 9 except 23 -> 00
    always_comb begin
        hr_units_d = hr_units_q;
        hr_tens_d  = hr_tens_q;
        if (hr_up) begin
            if (hr_tens_q == HT_LAST && hr_units_q == HU_LAST) begin
                hr_units_d = '0;
                hr_tens_d  = '0;
            end else if (hr_units_q == HU_NINE) begin
                hr_units_d = '0;
                hr_tens_d  = hr_tens_q + HT_W'(1);
            end else begin
                hr_units_d = hr_units_q + HU_W'(1);
            end
        end else if (hr_dn) begin
            if (hr_tens_q == '0 && hr_units_q == '0) begin
                hr_units_d = HU_LAST;
                hr_tens_d  = HT_LAST;
            end else if (hr_units_q == '0) begin
                hr_units_d = HU_NINE;
                hr_tens_d  = hr_tens_q - HT_W'(1);
            end else begin
                hr_units_d = hr_units_q - HU_W'(1);
            end
        end
    end

    // Alarm digit registers, cleared to 00:00
    always_ff @(posedge clk) begin
        if (reset) begin
            min_units_q <= '0;
            min_tens_q  <= '0;
            hr_units_q  <= '0;
            hr_tens_q   <= '0;
        end else begin
            min_units_q <= min_units_d;
            min_tens_q  <= min_tens_d;
            hr_units_q  <= hr_units_d;
            hr_tens_q   <= hr_tens_d;
        end
    end

    assign al_min_units = min_units_q;
    assign al_min_tens  = min_tens_q;
    assign al_hr_units  = hr_units_q;
    assign al_hr_tens   = hr_tens_q;

endmodule

// File: rtl/alarm_match_ctrl.sv
// Alarm controller: matches live HH:MM:00 against the alarm time and
// sequences armed / ringing / snooze / timeout.
module alarm_match_ctrl
    import alarm_match_ctrl_pkg::*;
#(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned CNT_W       = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      sec_units,
    input  logic [2:0]      sec_tens,
    input  logic [3:0]      min_units,
    input  logic [2:0]      min_tens,
    input  logic [3:0]      hr_units,
    input  logic [1:0]      hr_tens,
    input  logic            alarm_en,
    input  logic            set_mode,
    input  logic            c_up_min,
    input  logic            c_down_min,
    input  logic            c_up_hour,
    input  logic            c_down_hour,
    input  logic            stop,
    input  logic            snooze,
    output logic [MU_W-1:0] al_min_units,
    output logic [MT_W-1:0] al_min_tens,
    output logic [HU_W-1:0] al_hr_units,
    output logic [HT_W-1:0] al_hr_tens,
    output logic            ringing,
    output logic            armed
);

    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);

    alarm_state_e     state_q, state_d;
    logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [CNT_W-1:0] snz_cnt_q, snz_cnt_d;
    logic             ringing_q, armed_q;
    logic             match, match_d, match_rise;
    logic [3:0]       sec_units_d;
    logic             sec_tick;

    alarm_time_reg u_time_reg (
        .clk          (clk),
        .reset        (reset),
        .set_mode     (set_mode),
        .c_up_min     (c_up_min),
        .c_down_min   (c_down_min),
        .c_up_hour    (c_up_hour),
        .c_down_hour  (c_down_hour),
        .al_min_units (al_min_units),
        .al_min_tens  (al_min_tens),
        .al_hr_units  (al_hr_units),
        .al_hr_tens   (al_hr_tens)
    );

    // Any change of the live seconds units digit marks a new second
    assign sec_tick = (sec_units != sec_units_d);

    assign match = (hr_tens == al_hr_tens) && (hr_units == al_hr_units) &&
                   (min_tens == al_min_tens) && (min_units == al_min_units) &&
                   (sec_tens == '0) && (sec_units == '0);
    // One trigger per qualifying second, however long the time is held
    assign match_rise = match & ~match_d;

    // Next state and counters; alarm_en = 0 overrides everything
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        if (!alarm_en) begin
            state_d    = StIdle;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StArmed;
                StArmed: begin
                    if (match_rise && !set_mode) begin
                        state_d    = StRinging;
                        ring_cnt_d = '0;
                    end
                end
                StRinging: begin
                    if (stop) begin
                        state_d = StArmed;
                    end else if (snooze) begin
                        state_d   = StSnoozing;
                        snz_cnt_d = '0;
                    end else if (sec_tick) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_d = StArmed;
                        end else begin
                            ring_cnt_d = ring_cnt_q + CNT_W'(1);
                        end
                    end
                end
                StSnoozing: begin
                    if (stop) begin
                        state_d = StArmed;
                    end else if (sec_tick) begin
                        if (snz_cnt_q == SNOOZE_LAST) begin
                            state_d    = StRinging;
                            ring_cnt_d = '0;
                        end else begin
                            snz_cnt_d = snz_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, counters, edge-detect history and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ring_cnt_q  <= '0;
            snz_cnt_q   <= '0;
            match_d     <= 1'b0;
            sec_units_d <= '0;
            ringing_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ring_cnt_q  <= ring_cnt_d;
            snz_cnt_q   <= snz_cnt_d;
            match_d     <= match;
            sec_units_d <= sec_units;
            ringing_q   <= (state_d == StRinging);
            armed_q     <= (state_d != StIdle);
        end
    end

    assign ringing = ringing_q;
    assign armed   = armed_q;

endmodule

// File: tb/tb_alarm_match_ctrl.sv
// Directed self-checking bench for alarm_match_ctrl.
module tb_alarm_match_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] sec_units;
    logic [2:0] sec_tens;
    logic [3:0] min_units;
    logic [2:0] min_tens;
    logic [3:0] hr_units;
    logic [1:0] hr_tens;
    logic       alarm_en, set_mode;
    logic       c_up_min, c_down_min, c_up_hour, c_down_hour;
    logic       stop, snooze;
    logic [3:0] al_min_units;
    logic [2:0] al_min_tens;
    logic [3:0] al_hr_units;
    logic [1:0] al_hr_tens;
    logic       ringing, armed;

    int n_tests = 0;
    int n_fail  = 0;
    int hh = 0, mm = 0, ss = 0;

    alarm_match_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .sec_units    (sec_units),
        .sec_tens     (sec_tens),
        .min_units    (min_units),
        .min_tens     (min_tens),
        .hr_units     (hr_units),
        .hr_tens      (hr_tens),
        .alarm_en     (alarm_en),
        .set_mode     (set_mode),
        .c_up_min     (c_up_min),
        .c_down_min   (c_down_min),
        .c_up_hour    (c_up_hour),
        .c_down_hour  (c_down_hour),
        .stop         (stop),
        .snooze       (snooze),
        .al_min_units (al_min_units),
        .al_min_tens  (al_min_tens),
        .al_hr_units  (al_hr_units),
        .al_hr_tens   (al_hr_tens),
        .ringing      (ringing),
        .armed        (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] hm(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [12:0] alarm_now();
        return {al_hr_tens, al_hr_units, al_min_tens, al_min_units};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_time();
        sec_units = 4'(ss % 10);
        sec_tens  = 3'(ss / 10);
        min_units = 4'(mm % 10);
        min_tens  = 3'(mm / 10);
        hr_units  = 4'(hh % 10);
        hr_tens   = 2'(hh / 10);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hh = h; mm = m; ss = s;
        apply_time();
        step();
    endtask

    // Advance the live clock one second per cycle, n times
    task automatic ticks(input int n);
        repeat (n) begin
            ss++;
            if (ss == 60) begin
                ss = 0;
                mm++;
                if (mm == 60) begin
                    mm = 0;
                    hh = (hh + 1) % 24;
                end
            end
            apply_time();
            step();
        end
    endtask

    task automatic adj(input logic uh, input logic dh, input logic um, input logic dm);
        c_up_hour = uh; c_down_hour = dh; c_up_min = um; c_down_min = dm;
        step();
        c_up_hour = 1'b0; c_down_hour = 1'b0; c_up_min = 1'b0; c_down_min = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
    endtask

    task automatic trigger();
        set_time(7, 29, 59);
        set_time(7, 30, 0);
    endtask

    initial begin
        reset = 1'b1;
        alarm_en = 1'b0; set_mode = 1'b0;
        c_up_min = 1'b0; c_down_min = 1'b0; c_up_hour = 1'b0; c_down_hour = 1'b0;
        stop = 1'b0; snooze = 1'b0;
        set_time(12, 0, 5);
        step();
        check("reset_ringing", 32'(ringing), 32'd0);
        check("reset_armed", 32'(armed), 32'd0);
        check("reset_alarm", 32'(alarm_now()), 32'(hm(0, 0)));
        reset = 1'b0;

        // Editing and wrap boundaries
        set_mode = 1'b1;
        adj(0, 1, 0, 0);
        check("hr_down_wrap", 32'(alarm_now()), 32'(hm(23, 0)));
        adj(0, 0, 0, 1);
        check("min_down_wrap", 32'(alarm_now()), 32'(hm(23, 59)));
        adj(1, 0, 0, 0);
        check("hr_up_wrap", 32'(alarm_now()), 32'(hm(0, 59)));
        adj(0, 0, 1, 0);
        check("min_up_no_carry", 32'(alarm_now()), 32'(hm(0, 0)));
        adj(1, 1, 1, 1);
        check("up_down_cancel", 32'(alarm_now()), 32'(hm(0, 0)));
        adj(1, 0, 1, 0);
        check("both_fields", 32'(alarm_now()), 32'(hm(1, 1)));
        set_mode = 1'b0;
        adj(1, 0, 1, 0);
        check("no_edit_wo_set_mode", 32'(alarm_now()), 32'(hm(1, 1)));

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_clears_alarm", 32'(alarm_now()), 32'(hm(0, 0)));
        set_mode = 1'b1;
        repeat (7) adj(1, 0, 0, 0);
        repeat (30) adj(0, 0, 1, 0);
        check("set_0730", 32'(alarm_now()), 32'(hm(7, 30)));
        set_mode = 1'b0;

        // Arm and trigger
        alarm_en = 1'b1;
        step();
        check("armed_after_en", 32'(armed), 32'd1);
        set_time(7, 29, 59);
        check("no_ring_before", 32'(ringing), 32'd0);
        set_time(7, 30, 0);
        check("ring_on_match", 32'(ringing), 32'd1);
        repeat (20) step();
        check("ring_held", 32'(ringing), 32'd1);
        pulse_stop();
        check("stop_silences", 32'(ringing), 32'd0);
        repeat (10) step();
        check("single_trigger", 32'(ringing), 32'd0);
        check("armed_after_stop", 32'(armed), 32'd1);

        // Ring timeout on the 60th tick
        trigger();
        check("retrigger", 32'(ringing), 32'd1);
        ticks(59);
        check("ring_59_ticks", 32'(ringing), 32'd1);
        ticks(1);
        check("ring_timeout", 32'(ringing), 32'd0);
        check("armed_timeout", 32'(armed), 32'd1);

        // Snooze and re-ring after 300 ticks
        trigger();
        check("ring_before_snooze", 32'(ringing), 32'd1);
        pulse_snooze();
        check("snooze_silences", 32'(ringing), 32'd0);
        check("snooze_armed", 32'(armed), 32'd1);
        ticks(299);
        check("snooze_299", 32'(ringing), 32'd0);
        ticks(1);
        check("snooze_rering", 32'(ringing), 32'd1);
        pulse_stop();
        check("stop_rering", 32'(ringing), 32'd0);
        check("armed_after_rering", 32'(armed), 32'd1);

        // Stop wins over snooze
        trigger();
        stop = 1'b1; snooze = 1'b1;
        step();
        stop = 1'b0; snooze = 1'b0;
        check("stop_snooze_ring", 32'(ringing), 32'd0);
        ticks(300);
        check("stop_beats_snooze", 32'(ringing), 32'd0);

        // alarm_en dropped while snoozing clears the pending re-ring
        trigger();
        pulse_snooze();
        alarm_en = 1'b0;
        step();
        check("en_off_armed", 32'(armed), 32'd0);
        check("en_off_ringing", 32'(ringing), 32'd0);
        alarm_en = 1'b1;
        step();
        check("en_on_armed", 32'(armed), 32'd1);
        ticks(300);
        check("no_pending_rering", 32'(ringing), 32'd0);

        // set_mode blocks a trigger
        set_mode = 1'b1;
        trigger();
        check("set_mode_blocks", 32'(ringing), 32'd0);
        repeat (3) step();
        set_mode = 1'b0;
        step();
        check("set_mode_no_late", 32'(ringing), 32'd0);

        // Reset while ringing
        trigger();
        check("ring_before_reset", 32'(ringing), 32'd1);
        reset = 1'b1;
        step();
        check("reset_mid_ring", 32'(ringing), 32'd0);
        check("reset_mid_armed", 32'(armed), 32'd0);
        check("reset_mid_alarm", 32'(alarm_now()), 32'(hm(0, 0)));
        reset = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_match_ctrl.md
Name: alarm_match_ctrl

Overview:
- Consumer of the six BCD time digits (HH:MM:SS) produced by the time-of-day counter.
- Holds a user-set alarm time (HH:MM, 24 h, BCD) and detects the exact second the live time reaches HH:MM:00.
- Sequences the alarm through armed, ringing, snooze and timeout states, and drives the buzzer/LED request and alarm digits for the display path.

Parameters:
- RING_SECS, 60, seconds the alarm rings before auto-timeout back to ARMED.
- SNOOZE_SECS, 300, seconds spent in SNOOZING before re-ringing.
- CNT_W, 9, width of the ring/snooze second counters; must hold max(RING_SECS, SNOOZE_SECS) - 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sec_units  in  4  live seconds units digit, 0-9.
- sec_tens  in  3  live seconds tens digit, 0-5.
- min_units  in  4  live minutes units digit, 0-9.
- min_tens  in  3  live minutes tens digit, 0-5.
- hr_units  in  4  live hours units digit, 0-9.
- hr_tens  in  2  live hours tens digit, 0-2.
- alarm_en  in  1  level; 0 disables the alarm entirely.
- set_mode  in  1  level; 1 lets the adjust pulses edit the alarm time and blocks new triggers.
- c_up_min  in  1  single-cycle pulse; increments alarm minutes.
- c_down_min  in  1  single-cycle pulse; decrements alarm minutes.
- c_up_hour  in  1  single-cycle pulse; increments alarm hours.
- c_down_hour  in  1  single-cycle pulse; decrements alarm hours.
- stop  in  1  single-cycle pulse; silences the alarm.
- snooze  in  1  single-cycle pulse; enters snooze.
- al_min_units  out  4  alarm minutes units digit.
- al_min_tens  out  3  alarm minutes tens digit.
- al_hr_units  out  4  alarm hours units digit.
- al_hr_tens  out  2  alarm hours tens digit.
- ringing  out  1  buzzer request; high only in RINGING.
- armed  out  1  high in ARMED, RINGING and SNOOZING.

Behaviour:
- Reset, synchronous and active-high on clk:
  - state = IDLE; alarm time = 00:00; ringing = 0; armed = 0.
  - ring_cnt = 0; snz_cnt = 0; match_d = 0; sec_units_d = 0.
- Alarm time editing:
  - Adjust pulses act only when set_mode = 1; they are allowed in any state.
  - Minutes wrap 59 -> 00 on up and 00 -> 59 on down, with no carry into hours.
  - Hours wrap 23 -> 00 on up and 00 -> 23 on down, handled as 0-23 in BCD (hr_tens = 2 caps hr_units at 3).
  - Up and down on the same field in the same cycle: no change.
  - Minute and hour pulses in the same cycle: both fields update.
- Second tick:
  - sec_tick = (sec_units != sec_units_d).
  - sec_units_d registers sec_units every cycle.
- Match detection:
  - match = live HH:MM equal to alarm HH:MM, and sec_tens = 0, and sec_units = 0.
  - match_d registers match every cycle.
  - match_rise = match & ~match_d.
  - A trigger is therefore exactly one cycle per qualifying second.
- FSM, priority top-down each cycle:
  - Any state: alarm_en = 0 -> IDLE; ring_cnt and snz_cnt are cleared.
  - IDLE: alarm_en = 1 -> ARMED (next cycle).
  - ARMED: match_rise & ~set_mode -> RINGING, with ring_cnt = 0.
  - RINGING:
    - stop -> ARMED.
    - else snooze -> SNOOZING, with snz_cnt = 0.
    - else on sec_tick: if ring_cnt = RING_SECS-1 -> ARMED, otherwise ring_cnt + 1.
  - SNOOZING:
    - stop -> ARMED.
    - else on sec_tick: if snz_cnt = SNOOZE_SECS-1 -> RINGING with ring_cnt = 0, otherwise snz_cnt + 1.
    - snooze is ignored in this state.
- Outputs:
  - ringing and armed are registered, decoded from the next state; ringing rises the cycle after match_rise.
  - Alarm digits are registered and update the cycle after the adjust pulse.
- Reset mid-RINGING or mid-SNOOZING: IDLE next cycle, ringing = 0, no pending re-ring.
- Alarm re-edited during SNOOZING: the snooze timer still expires and rings. A fresh match at the new time while SNOOZING is ignored.

Decomposition:
- Shared package holds:
  - state encoding IDLE/ARMED/RINGING/SNOOZING (2 bits);
  - BCD limits MIN_MAX = 59, HR_MAX = 23;
  - digit widths 4/3/4/2.
- One sub-module, alarm_time_reg:
  - inputs: clk, reset, set_mode, the four adjust pulses;
  - outputs: the four alarm digits;
  - responsibility: BCD wrap logic.
- The top level holds the FSM, match logic, tick detection and counters.

Test Plan:
- Reset, then set_mode = 1, 7 c_up_hour and 30 c_up_min pulses -> alarm = 07:30. Then 1 c_down_hour from 00 (after reset) -> alarm = 23:00.
- alarm_en = 1, alarm 07:30, live time steps 07:29:59 -> 07:30:00 -> ringing = 1 one cycle later. Holding 07:30:00 for many cycles -> exactly one trigger.
- Ringing, no input, 60 sec_units changes -> ringing falls on the 60th tick; state ARMED.
- Ringing, snooze pulse -> ringing = 0 next cycle. After 300 ticks -> ringing = 1. Then stop -> ringing = 0, armed = 1.
- Ringing, stop and snooze in the same cycle -> ARMED, not SNOOZING. alarm_en dropped during SNOOZING -> IDLE, armed = 0, no re-ring after 300 ticks.
- set_mode = 1 while live time hits alarm HH:MM:00 -> no trigger. Synchronous reset asserted while ringing -> ringing = 0 and alarm = 00:00 next cycle.
